// File: rtl/song_sequencer_if.sv
// Song memory read port: one-cycle request with address, data returned
// one or more cycles later with a one-cycle valid strobe.
interface song_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [9:0]        rd_data;

  // Sequencer side issues requests and consumes returned entries.
  modport master (
    output rd_req,
    output rd_addr,
    input  rd_valid,
    input  rd_data
  );

  // Memory side answers requests.
  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks song memory one entry at a time, holding each
// note on current_track for dur note ticks (TICK_DIV clocks per tick).
// An entry is {dur[3:0], note[5:0]}; dur == 0 ends the song.
// Supports play / pause / resume / stop, with stop > pause > play.
// Optional macro ARTICULATION_GAP_EN silences the last 1/8 of the final
// tick of each note so repeated notes are heard as separate notes.
module song_sequencer #(
  parameter int TICK_DIV = 375000,
  parameter int ADDR_W   = 8
) (
  input  logic              clk_6mhz,
  input  logic              reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [ADDR_W-1:0] song_base,
  song_sequencer_if.master  mem,
  output logic [5:0]        current_track,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
`ifdef ARTICULATION_GAP_EN
  // One extra bit so the threshold never aliases when TICK_DIV/8 is 0.
  localparam logic [CNT_W:0] GAP_START = (CNT_W + 1)'(TICK_DIV - TICK_DIV / 8);
`endif

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    PAUSED
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        note_q, note_d;
  logic [3:0]        remain_q, remain_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic              done_q, done_d;

  logic [3:0] entryDur;
  logic [5:0] entryNote;

  assign entryDur  = mem.rd_data[9:6];
  assign entryNote = mem.rd_data[5:0];

  // State and datapath registers; reset returns everything to idle silence.
  always_ff @(posedge clk_6mhz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      note_q   <= '0;
      remain_q <= '0;
      tick_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      remain_q <= remain_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; a pause in PLAY freezes the tick counter that cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    remain_d = remain_q;
    tick_d   = tick_q;
    done_d   = 1'b0;

    if (stop) begin
      state_d = IDLE;
      note_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            addr_d  = song_base;
            state_d = FETCH;
          end
        end

        FETCH: begin
          state_d = WAIT;
        end

        WAIT: begin
          if (mem.rd_valid) begin
            if (entryDur == 4'd0) begin
              done_d  = 1'b1;
              note_d  = '0;
              state_d = IDLE;
            end else begin
              note_d   = entryNote;
              remain_d = entryDur;
              tick_d   = '0;
              addr_d   = addr_q + 1'b1;
              state_d  = PLAY;
            end
          end
        end

        PLAY: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            remain_d = remain_q - 4'd1;
            if (remain_q == 4'd1) begin
              state_d = FETCH;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        PAUSED: begin
          if (play) begin
            state_d = PLAY;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs: the held note stays on during fetches so notes join seamlessly.
  always_comb begin
    mem.rd_req    = (state_q == FETCH);
    mem.rd_addr   = addr_q;
    busy          = (state_q != IDLE);
    done          = done_q;
    current_track = (state_q == PAUSED) ? 6'd0 : note_q;
`ifdef ARTICULATION_GAP_EN
    if ((state_q == PLAY) && (remain_q == 4'd1) && ({1'b0, tick_q} >= GAP_START)) begin
      current_track = 6'd0;
    end
`endif
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Plays a song on the single-track tone generator by stepping through note entries held in a song memory.
- Fetches one entry at a time over a request/valid read port.
- Holds each note on current_track for its programmed number of 1/16-second ticks, then fetches the next entry.
- Supports play, pause, resume and stop; sits between the MMIO piano control registers and the one-track player.

Parameters:
- TICK_DIV, 375000, clk_6mhz cycles per note tick (6 MHz / 16 Hz); benches use a small value.
- ADDR_W, 8, song memory address width.

Ports:
- clk_6mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  1-cycle pulse: start from song_base when idle; resume when paused
- pause  in  1  1-cycle pulse: pause playback
- stop  in  1  1-cycle pulse: abort playback, go idle
- song_base  in  ADDR_W  first entry address, sampled on play from IDLE
- rd_req  out  1  1-cycle memory read request
- rd_addr  out  ADDR_W  read address, valid while rd_req=1
- rd_valid  in  1  read data valid, 1 cycle, arrives 1 or more cycles after rd_req
- rd_data  in  10  song entry: {dur[3:0], note[5:0]}; dur=0 marks end of song
- current_track  out  6  note index to the player; 0 = silence
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse when the end marker is read

Behaviour:
- Reset values: rd_req=0, rd_addr=0, current_track=0, busy=0, done=0, state=IDLE, internal address=0, remaining-tick count=0, tick counter=0.
- Control priority in a single cycle: stop > pause > play.
- IDLE:
  - current_track=0.
  - play: address <= song_base, go to FETCH.
  - pause and stop are no-ops.
- FETCH (1 cycle):
  - rd_req=1, rd_addr=address.
  - Next state WAIT.
- WAIT:
  - rd_req=0; current_track keeps the previous note, so there is no gap between notes.
  - On rd_valid with dur=0: done=1 for 1 cycle, current_track<=0, go to IDLE.
  - On rd_valid with dur!=0: current_track<=note, remaining<=dur, tick counter<=0, address<=address+1 (wraps modulo 2^ADDR_W), go to PLAY.
- PLAY:
  - Tick counter counts 0..TICK_DIV-1, then wraps; each wrap is a tick.
  - On each tick remaining decrements.
  - On the tick where remaining==1, go to FETCH.
  - A note of dur d therefore lasts d*TICK_DIV cycles in PLAY, plus the fetch latency of the next entry.
- PAUSED:
  - Entered from PLAY on pause. current_track output=0; the note, remaining count and tick counter are frozen.
  - On play: restore the note and return to PLAY, continuing exactly where it stopped.
- Ignored or special events:
  - pause in FETCH or WAIT is ignored.
  - play in FETCH, WAIT or PLAY is ignored.
  - stop in any state: IDLE next cycle, current_track=0, rd_req=0, no done pulse.
  - rd_valid outside WAIT is ignored, including a late response after stop.
- Reset mid-note: outputs return to their reset values immediately.

Optional Feature:
- Macro: ARTICULATION_GAP_EN.
- Defined: during the final tick of every note, current_track=0 once the tick counter is >= TICK_DIV - TICK_DIV/8. This gives a short audible break between repeated notes. Timing, state transitions and fetch start are unchanged.
- Undefined: the note is held for its full duration, with no gap.

Test Plan (TICK_DIV=8, memory returns rd_valid 2 cycles after rd_req):
- Memory[0x10]={2,5}, [0x11]={1,12}, [0x12]={0,0}; song_base=0x10; pulse play.
  - rd_addr 0x10, 0x11, 0x12 issued in order.
  - current_track=5 for 16 PLAY cycles, then 12 for 8 PLAY cycles.
  - done pulses once; current_track=0; busy=0.
- Pause after 3 cycles of a dur=1 note=7, wait 20 cycles, then play.
  - current_track=0 while paused.
  - After resume, 7 is held for the remaining 5 cycles, then FETCH.
- Pulse stop while in WAIT, then inject rd_valid={3,9}.
  - State stays IDLE, current_track=0, no done pulse.
- song_base=0xFF, entry {1,3} at 0xFF, end marker at 0x00.
  - Second read goes to rd_addr=0x00 (address wrap).
- play, pause and stop all pulsed in the same cycle while in PLAY.
  - Next cycle is IDLE, current_track=0.
- With ARTICULATION_GAP_EN, entry {1,4}: current_track=4 for 7 cycles, then 0 for 1 cycle (TICK_DIV/8=1).
